// File: rtl/sync_debounce_pkg.sv
// Shared constants and helpers for the multi-channel synchronise-and-debounce block.
package sync_debounce_pkg;

  // Counter width for a stability filter: ceil(log2(stable_cycles)), never below one bit.
  function automatic int cnt_width(input int stable_cycles);
    int w;
    w = 0;
    while ((32'sd1 <<< w) < stable_cycles) begin
      w = w + 32'sd1;
    end
    if (w < 32'sd1) begin
      w = 32'sd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_debounce_chan.sv
// One channel: N-stage synchroniser, stability counter, filtered level and edge strobes.
module sync_debounce_chan
  import sync_debounce_pkg::*;
#(
  parameter int   N             = 2,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N-1:0]     sync_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             out_r;
  logic             rise_r;
  logic             fall_r;
  logic             sn_s;
  logic             out_nxt_s;
  logic             rise_nxt_s;
  logic             fall_nxt_s;
  logic             accept_s;

  assign sn_s = sync_r[N-1];

  // Filter next state: any return to the current level restarts the count.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    out_nxt_s  = out_r;
    rise_nxt_s = 1'b0;
    fall_nxt_s = 1'b0;
    accept_s   = 1'b0;
    if (sn_s == out_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_nxt_s  = {CNT_W{1'b0}};
      out_nxt_s  = sn_s;
      rise_nxt_s = sn_s;
      fall_nxt_s = ~sn_s;
      accept_s   = 1'b1;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Synchroniser chain, counter, filtered level and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {N{RESET_BIT}};
      cnt_r  <= {CNT_W{1'b0}};
      out_r  <= RESET_BIT;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[N-2:0], in};
      cnt_r  <= cnt_nxt_s;
      out_r  <= out_nxt_s;
      rise_r <= rise_nxt_s;
      fall_r <= fall_nxt_s;
    end
  end

  assign out    = out_r;
  assign rise   = rise_r;
  assign fall   = fall_r;
  assign accept = accept_s;

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchroniser with per-channel debounce filter and edge strobes.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               N             = 2,
  parameter int               STABLE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] accept_s;
  logic             changed_r;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    sync_debounce_chan #(
      .N             (N),
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_BIT     (RESET_VAL[g])
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (in[g]),
      .out    (out[g]),
      .rise   (rise[g]),
      .fall   (fall[g]),
      .accept (accept_s[g])
    );
  end

  // Summary strobe, registered alongside the per-channel strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_r <= 1'b0;
    end else begin
      changed_r <= |accept_s;
    end
  end

  assign changed = changed_r;

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench: main config (WIDTH=4, N=2, S=4) plus a minimal-filter config (N=3, S=1).
module tb_sync_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_a;
  logic [3:0] out_a;
  logic [3:0] rise_a;
  logic [3:0] fall_a;
  logic       changed_a;
  logic [0:0] in_b;
  logic [0:0] out_b;
  logic [0:0] rise_b;
  logic [0:0] fall_b;
  logic       changed_b;

  int vec_cnt;
  int err_cnt;
  int rise_cnt [4];

  sync_debounce #(.WIDTH(4), .N(2), .STABLE_CYCLES(4), .RESET_VAL(4'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .out(out_a),
    .rise(rise_a), .fall(fall_a), .changed(changed_a)
  );

  sync_debounce #(.WIDTH(1), .N(3), .STABLE_CYCLES(1), .RESET_VAL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .out(out_b),
    .rise(rise_b), .fall(fall_b), .changed(changed_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt = vec_cnt + 1;
    if (got !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and sample 1 ns later, tallying rise pulses of dut_a.
  task automatic tick(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (rise_a[c]) rise_cnt[c] = rise_cnt[c] + 1;
      end
    end
  endtask

  task automatic clr_rise();
    for (int c = 0; c < 4; c++) rise_cnt[c] = 0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    clr_rise();
    rst_n = 1'b0;
    in_a  = 4'hF;
    in_b  = 1'b0;

    // 1. reset release with inputs already high
    tick(3);
    check_val("rst_out", {28'd0, out_a}, 32'h0);
    check_val("rst_rise", {28'd0, rise_a}, 32'h0);
    check_val("rst_changed", {31'd0, changed_a}, 32'h0);
    check_val("rst_out_b", {31'd0, out_b}, 32'h0);
    rst_n = 1'b1;
    tick(5);
    check_val("rel_out_early", {28'd0, out_a}, 32'h0);
    tick(1);
    check_val("rel_out", {28'd0, out_a}, 32'hF);
    check_val("rel_rise", {28'd0, rise_a}, 32'hF);
    check_val("rel_changed", {31'd0, changed_a}, 32'h1);
    tick(1);
    check_val("rel_rise_clr", {28'd0, rise_a}, 32'h0);
    check_val("rel_changed_clr", {31'd0, changed_a}, 32'h0);

    // drop all to zero: fall strobes
    in_a = 4'h0;
    tick(6);
    check_val("drop_out", {28'd0, out_a}, 32'h0);
    check_val("drop_fall", {28'd0, fall_a}, 32'hF);
    check_val("drop_rise", {28'd0, rise_a}, 32'h0);
    tick(2);

    // 2. glitch rejection: 3 clocks high
    clr_rise();
    in_a = 4'h1;
    tick(3);
    in_a = 4'h0;
    tick(10);
    check_val("glitch_out", {28'd0, out_a}, 32'h0);
    check_val("glitch_rise", rise_cnt[0], 32'd0);
    // 4 clocks high is accepted
    in_a = 4'h1;
    tick(4);
    in_a = 4'h0;
    tick(1);
    check_val("four_out_early", {28'd0, out_a}, 32'h0);
    tick(1);
    check_val("four_out", {28'd0, out_a}, 32'h1);
    check_val("four_rise", {28'd0, rise_a}, 32'h1);
    tick(12);
    check_val("four_settle", {28'd0, out_a}, 32'h0);

    // 3. bounce: high 2, low 1, then high steady
    clr_rise();
    in_a = 4'h2;
    tick(2);
    in_a = 4'h0;
    tick(1);
    in_a = 4'h2;
    tick(5);
    check_val("bounce_early", {28'd0, out_a}, 32'h0);
    tick(1);
    check_val("bounce_out", {28'd0, out_a}, 32'h2);
    check_val("bounce_rise", {28'd0, rise_a}, 32'h2);
    tick(4);
    check_val("bounce_pulses", rise_cnt[1], 32'd1);

    // 4. simultaneous opposite transitions
    in_a = 4'h8;
    tick(8);
    check_val("sim_pre", {28'd0, out_a}, 32'h8);
    in_a = 4'h4;
    tick(5);
    check_val("sim_early", {28'd0, out_a}, 32'h8);
    tick(1);
    check_val("sim_out", {28'd0, out_a}, 32'h4);
    check_val("sim_rise", {28'd0, rise_a}, 32'h4);
    check_val("sim_fall", {28'd0, fall_a}, 32'h8);
    check_val("sim_changed", {31'd0, changed_a}, 32'h1);
    tick(1);
    check_val("sim_quiet", {27'd0, changed_a, rise_a | fall_a}, 32'h0);

    // 5. async reset mid-count
    in_a = 4'hF;
    tick(8);
    check_val("mid_pre", {28'd0, out_a}, 32'hF);
    in_a = 4'hE;
    tick(4);
    check_val("mid_hold", {28'd0, out_a}, 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out", {28'd0, out_a}, 32'h0);
    check_val("mid_rst_strb", {27'd0, changed_a, rise_a | fall_a}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    clr_rise();
    tick(5);
    check_val("mid_rel_out", {28'd0, out_a}, 32'h0);
    check_val("mid_rel_quiet", rise_cnt[1] + rise_cnt[2] + rise_cnt[3], 32'd0);
    tick(1);
    check_val("mid_rel_rise", {28'd0, rise_a}, 32'hE);
    check_val("mid_rel_newout", {28'd0, out_a}, 32'hE);

    // 6. minimal filter: N=3, S=1
    in_b = 1'b1;
    tick(3);
    check_val("min_early", {31'd0, out_b}, 32'h0);
    tick(1);
    check_val("min_out", {31'd0, out_b}, 32'h1);
    check_val("min_rise", {31'd0, rise_b}, 32'h1);
    check_val("min_changed", {31'd0, changed_b}, 32'h1);
    in_b = 1'b0;
    tick(6);
    check_val("min_back", {31'd0, out_b}, 32'h0);
    in_b = 1'b1;
    tick(1);
    in_b = 1'b0;
    tick(2);
    check_val("pulse_early", {31'd0, out_b}, 32'h0);
    tick(1);
    check_val("pulse_hi", {30'd0, rise_b, out_b}, 32'h3);
    tick(1);
    check_val("pulse_lo", {30'd0, fall_b, out_b}, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
